reg_bank_param: RTL and testbench

Parametrised register bank that replaces the fixed 256 x 32-bit bank behind the AXI4-Lite slave. It adds configurable width, depth and base address, per-byte write strobes, read-only registers, address/access error reporting, and valid/ready request and response channels with a registered one-cycle read. It sits between the AXI4-Lite protocol front end and the user logic. The front end maps the responses onto BRESP/RRESP: OKAY when err=0, SLVERR when err=1.

---
 rtl/reg_bank_param.sv | 129 ++++++++++++
 tb/tb_reg_bank_param.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_param.sv
// Parametrised register bank with byte-strobed writes, read-only registers,
// decode-error reporting and one registered response per valid/ready channel.
module reg_bank_param #(
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 256,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter logic [DEPTH-1:0]  RO_MASK   = '0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                wr_req_valid,
    output logic                wr_req_ready,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_strb,
    output logic                wr_resp_valid,
    input  logic                wr_resp_ready,
    output logic                wr_err,
    input  logic                rd_req_valid,
    output logic                rd_req_ready,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_resp_valid,
    input  logic                rd_resp_ready,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_err
);
    localparam int BYTES = DATA_W / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, RESP} state_t;

    typedef struct packed {
        logic             err;
        logic [IDX_W-1:0] idx;
    } dec_t;

    // The extra top bit of the subtraction is the borrow, i.e. addr < BASE_ADDR.
    function automatic dec_t decode(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W:0]   diff;
        logic [ADDR_W-1:0] word;
        dec_t              d;
        diff  = {1'b0, addr} - {1'b0, BASE_ADDR};
        word  = diff[ADDR_W-1:0] >> LSB;
        d.idx = word[IDX_W-1:0];
        d.err = diff[ADDR_W] || (diff[LSB-1:0] != '0) || (word >= ADDR_W'(DEPTH));
        return d;
    endfunction

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] cur,
                                                 input logic [DATA_W-1:0] wdat,
                                                 input logic [BYTES-1:0]  strb);
        logic [DATA_W-1:0] r;
        r = cur;
        for (int k = 0; k < BYTES; k++) begin
            if (strb[k]) r[8*k +: 8] = wdat[8*k +: 8];
        end
        return r;
    endfunction

    state_t            wr_state, wr_state_nxt;
    state_t            rd_state, rd_state_nxt;
    dec_t              wr_dec, rd_dec;
    logic              wr_acc, rd_acc, wr_ro;
    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_err_p1, rd_err_p1;
    logic [DATA_W-1:0] rd_data_p1;

    assign wr_dec = decode(wr_addr);
    assign rd_dec = decode(rd_addr);
    assign wr_ro  = !wr_dec.err && RO_MASK[wr_dec.idx];

    assign wr_resp_valid = (wr_state == RESP);
    assign rd_resp_valid = (rd_state == RESP);
    assign wr_req_ready  = !wr_resp_valid || wr_resp_ready;
    assign rd_req_ready  = !rd_resp_valid || rd_resp_ready;
    assign wr_acc        = wr_req_valid && wr_req_ready;
    assign rd_acc        = rd_req_valid && rd_req_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_state <= IDLE;
            rd_state <= IDLE;
        end else begin
            wr_state <= wr_state_nxt;
            rd_state <= rd_state_nxt;
        end
    end

    // A new accept always wins over the handshake so back-to-back stays in RESP.
    always_comb begin
        wr_state_nxt = wr_state;
        rd_state_nxt = rd_state;
        if (wr_acc)                             wr_state_nxt = RESP;
        else if (wr_resp_valid && wr_resp_ready) wr_state_nxt = IDLE;
        if (rd_acc)                             rd_state_nxt = RESP;
        else if (rd_resp_valid && rd_resp_ready) rd_state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= RESET_VAL;
        end else if (wr_acc && !wr_dec.err && !wr_ro) begin
            regs[wr_dec.idx] <= merge(regs[wr_dec.idx], wr_data, wr_strb);
        end
    end

    // Response stage: captured only on accept so it holds while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_err_p1  <= 1'b0;
            rd_err_p1  <= 1'b0;
            rd_data_p1 <= '0;
        end else begin
            if (wr_acc) wr_err_p1 <= wr_dec.err || wr_ro;
            if (rd_acc) begin
                rd_err_p1  <= rd_dec.err;
                rd_data_p1 <= rd_dec.err ? '0 : regs[rd_dec.idx];
            end
        end
    end

    assign wr_err  = wr_err_p1;
    assign rd_err  = rd_err_p1;
    assign rd_data = rd_data_p1;

endmodule

// File: tb/tb_reg_bank_param.sv
// Scoreboard bench for reg_bank_param: a bench-side register model predicts each
// response at accept time; responses are popped and compared on handshake.
`timescale 1ns/1ps
module tb_reg_bank_param;
    localparam int          DATA_W = 32;
    localparam int          DEPTH  = 16;
    localparam int          ADDR_W = 32;
    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam logic [31:0] RVAL   = 32'h5A5A_0000;
    localparam logic [15:0] RO     = 16'h0080;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_req_valid = 1'b0, wr_req_ready;
    logic [31:0] wr_addr = '0, wr_data = '0;
    logic [3:0]  wr_strb = '0;
    logic        wr_resp_valid, wr_resp_ready = 1'b1, wr_err;
    logic        rd_req_valid = 1'b0, rd_req_ready;
    logic [31:0] rd_addr = '0;
    logic        rd_resp_valid, rd_resp_ready = 1'b1;
    logic [31:0] rd_data;
    logic        rd_err;

    always #5 clk = ~clk;

    reg_bank_param #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
        .BASE_ADDR(BASE), .RESET_VAL(RVAL), .RO_MASK(RO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .wr_resp_valid(wr_resp_valid), .wr_resp_ready(wr_resp_ready), .wr_err(wr_err),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr),
        .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready),
        .rd_data(rd_data), .rd_err(rd_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        rq[$];
    exp_t        wq[$];
    logic [31:0] mdl [DEPTH];

    function automatic logic [31:0] A(input int i);
        return BASE + 32'(4 * i);
    endfunction

    function automatic bit bad_addr(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a < BASE) || (off % 4 != 0) || (off / 4 >= DEPTH);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor/scoreboard: pop on response handshake, predict and push on accept.
    initial begin
        exp_t re, we;
        int   rd_first, wr_first, idx;
        bit   rd_new, wr_new;
        rd_new = 1; wr_new = 1; rd_first = 0; wr_first = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                rq.delete(); wq.delete();
                rd_new = 1; wr_new = 1;
                for (int i = 0; i < DEPTH; i++) mdl[i] = RVAL;
            end else begin
                if (rd_resp_valid) begin
                    if (rd_new) begin rd_first = cyc; rd_new = 0; end
                    if (rd_resp_ready) begin
                        check("rd_pending", rq.size() > 0, 1);
                        if (rq.size() > 0) begin
                            re = rq.pop_front();
                            check("rd_data", rd_data, re.data);
                            check("rd_err", rd_err, re.err);
                            check("rd_latency", rd_first - re.cyc, 1);
                        end
                        rd_new = 1;
                    end
                end
                if (wr_resp_valid) begin
                    if (wr_new) begin wr_first = cyc; wr_new = 0; end
                    if (wr_resp_ready) begin
                        check("wr_pending", wq.size() > 0, 1);
                        if (wq.size() > 0) begin
                            we = wq.pop_front();
                            check("wr_err", wr_err, we.err);
                            check("wr_latency", wr_first - we.cyc, 1);
                        end
                        wr_new = 1;
                    end
                end
                // Read is predicted before the write updates the model (same-edge read sees old value).
                if (rd_req_valid && rd_req_ready) begin
                    re.err  = bad_addr(rd_addr);
                    idx     = re.err ? 0 : int'((rd_addr - BASE) / 4);
                    re.data = re.err ? 32'h0 : mdl[idx];
                    re.cyc  = cyc;
                    rq.push_back(re);
                end
                if (wr_req_valid && wr_req_ready) begin
                    idx    = bad_addr(wr_addr) ? 0 : int'((wr_addr - BASE) / 4);
                    we.err = bad_addr(wr_addr) ? 1'b1 : RO[idx];
                    if (!we.err) begin
                        for (int k = 0; k < 4; k++)
                            if (wr_strb[k]) mdl[idx][8*k +: 8] = wr_data[8*k +: 8];
                    end
                    we.data = '0;
                    we.cyc  = cyc;
                    wq.push_back(we);
                end
            end
        end
    end

    task automatic xfer(input bit do_wr, input logic [31:0] wa, input logic [31:0] wd,
                        input logic [3:0] ws, input bit do_rd, input logic [31:0] ra);
        bit ok;
        ok = 0;
        wr_req_valid = do_wr; wr_addr = wa; wr_data = wd; wr_strb = ws;
        rd_req_valid = do_rd; rd_addr = ra;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = (!do_wr || wr_req_ready) && (!do_rd || rd_req_ready);
        end
        check("req_accept_wait", ok, 1);
        @(posedge clk); #1;
        wr_req_valid = 0; rd_req_valid = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        xfer(1, a, d, s, 0, '0);
    endtask

    task automatic rd(input logic [31:0] a);
        xfer(0, '0, '0, '0, 1, a);
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] held;
        repeat (2) @(posedge clk); #1;
        check("rst_wr_resp_valid", wr_resp_valid, 0);
        check("rst_rd_resp_valid", rd_resp_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_wr_err", wr_err, 0);
        check("rst_rd_err", rd_err, 0);
        reset_n = 1;
        @(posedge clk); #1;
        check("wr_req_ready_after_rst", wr_req_ready, 1);
        check("rd_req_ready_after_rst", rd_req_ready, 1);

        rd(A(0));
        check("rst_val_idx0", rd_data, RVAL);
        rd(A(DEPTH-1));
        check("rst_val_last", rd_data, RVAL);

        wr(A(5), 32'hDEAD_BEEF, 4'b1111);
        wr(A(5), 32'h0000_00AA, 4'b0001);
        rd(A(5));
        check("strobe_merge", rd_data, 32'hDEAD_BEAA);
        wr(A(5), 32'hFFFF_FFFF, 4'b0000);
        check("strb0_err", wr_err, 0);
        rd(A(5));
        check("strb0_noop", rd_data, 32'hDEAD_BEAA);

        wr(A(7), 32'h1234_5678, 4'b1111);
        check("ro_wr_err", wr_err, 1);
        wr(BASE + 32'd2, 32'hFFFF_FFFF, 4'b1111);
        check("misalign_wr_err", wr_err, 1);
        wr(A(DEPTH), 32'hFFFF_FFFF, 4'b1111);
        check("range_wr_err", wr_err, 1);
        wr(BASE - 32'd4, 32'hFFFF_FFFF, 4'b1111);
        check("below_base_wr_err", wr_err, 1);
        rd(A(7));
        check("ro_unchanged", rd_data, RVAL);
        check("ro_rd_err", rd_err, 0);
        rd(A(0));
        check("idx0_unchanged", rd_data, RVAL);
        rd(A(DEPTH));
        check("range_rd_data", rd_data, 0);
        check("range_rd_err", rd_err, 1);

        wr(A(3), 32'h11, 4'b1111);
        xfer(1, A(3), 32'h22, 4'b1111, 1, A(3));
        check("same_cycle_old", rd_data, 32'h11);
        rd(A(3));
        check("next_read_new", rd_data, 32'h22);
        drain();

        rd_resp_ready = 0;
        rd_req_valid = 1; rd_addr = A(5);
        @(negedge clk);
        check("stall_first_ready", rd_req_ready, 1);
        @(posedge clk); #1;
        held = rd_data;
        check("stall_first_data", held, 32'hDEAD_BEAA);
        for (int i = 0; i < 4; i++) begin
            check("stall_ready_low", rd_req_ready, 0);
            check("stall_data_hold", rd_data, held);
            @(posedge clk); #1;
        end
        rd_resp_ready = 1;
        @(posedge clk); #1;
        rd_addr = A(3);
        check("b2b_valid0", rd_resp_valid, 1);
        check("b2b_data0", rd_data, 32'hDEAD_BEAA);
        @(posedge clk); #1;
        rd_addr = A(0);
        check("b2b_valid1", rd_resp_valid, 1);
        check("b2b_data1", rd_data, 32'h22);
        @(posedge clk); #1;
        rd_req_valid = 0;
        check("b2b_valid2", rd_resp_valid, 1);
        check("b2b_data2", rd_data, RVAL);
        drain();

        wr_resp_ready = 0; rd_resp_ready = 0;
        xfer(1, A(9), 32'h99, 4'b1111, 1, A(3));
        check("pre_rst_wr_valid", wr_resp_valid, 1);
        check("pre_rst_rd_valid", rd_resp_valid, 1);
        reset_n = 0; #1;
        check("async_rst_wr_valid", wr_resp_valid, 0);
        check("async_rst_rd_valid", rd_resp_valid, 0);
        check("async_rst_rd_data", rd_data, 0);
        repeat (2) @(posedge clk); #1;
        reset_n = 1; wr_resp_ready = 1; rd_resp_ready = 1;
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) begin
            rd(A(i));
            check("post_rst_val", rd_data, RVAL);
        end
        drain();
        check("rd_queue_empty", rq.size(), 0);
        check("wr_queue_empty", wq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
